// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: upstream command sequencer for the LCD controller.
// Host commands are buffered in a DEPTH-entry FIFO and issued one at a time
// on cmd/cmd_valid, using the controller's busy/done handshake. The issued
// command is held until the controller has finished with it. Issuing stops
// for good once done is seen after an issue (the WRITE command, 4'b0000).
// Optional feature: define LCD_SEQ_TIMEOUT_EN to add a wait-state watchdog
// (TIMEOUT cycles) that raises a sticky timeout_err and returns to IDLE.
module lcd_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic [AW:0]   fifo_level,
    output logic          illegal_cmd,
    output logic          seq_done
`ifdef LCD_SEQ_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(32'd0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(32'd1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    // Reject parameter sets the pointer arithmetic cannot support.
    generate
        if ((DEPTH < 32'sd2) || (DEPTH != (32'sd1 <<< AW)) || (TIMEOUT < 32'sd1)) begin : g_bad_cfg
            $error("lcd_cmd_seq: DEPTH must be 2**AW and >= 2, TIMEOUT >= 1");
        end
    endgenerate

    // Codes above 4'b1011 are not controller commands.
    function automatic logic is_legal_cmd(input logic [3:0] code);
        return (code <= 4'd11);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     level_r;
    logic [AW:0]     level_s;
    logic [3:0]      cmd_r;
    logic [3:0]      cmd_s;
    logic            cmd_valid_r;
    logic            cmd_valid_s;
    logic            seq_done_r;
    logic            seq_done_s;
    logic            illegal_r;
    logic            host_ready_r;
    logic            host_ready_s;
    logic            accept_s;
    logic            push_s;
    logic            drop_s;
    logic            pop_s;
    logic            tmo_expired_s;

    // Host handshake: accepted words are either queued or dropped as illegal.
    always_comb begin
        accept_s = host_valid && host_ready_r;
        if (accept_s) begin
            push_s = is_legal_cmd(host_cmd);
            drop_s = !is_legal_cmd(host_cmd);
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Next-state logic; done outranks the watchdog, which outranks busy.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!busy && (level_r != LVL_ZERO)) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (done) begin
                    state_s = ST_FINISH;
                end else if (tmo_expired_s) begin
                    state_s = ST_IDLE;
                end else if (busy) begin
                    state_s = ST_WAIT_LO;
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (done) begin
                    state_s = ST_FINISH;
                end else if (tmo_expired_s) begin
                    state_s = ST_IDLE;
                end else if (!busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end
            ST_FINISH: begin
                state_s = ST_FINISH;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: head is popped and latched only on the IDLE->ISSUE step.
    always_comb begin
        cmd_s = cmd_r;
        pop_s = 1'b0;
        if ((state_r == ST_IDLE) && (state_s == ST_ISSUE)) begin
            pop_s = 1'b1;
            cmd_s = mem_r[rd_ptr_r];
        end else begin
            pop_s = 1'b0;
            cmd_s = cmd_r;
        end
        cmd_valid_s = (state_s == ST_ISSUE);
        seq_done_s  = (state_s == ST_FINISH);
    end

    // Occupancy after this cycle's push/pop; drives the registered ready.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase
        host_ready_s = (level_s != LVL_FULL) && (state_s != ST_FINISH);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO storage and pointers; reset discards everything queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= host_cmd;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_s;
        end
    end

    // Registered outputs toward host and controller.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r        <= 4'd0;
            cmd_valid_r  <= 1'b0;
            seq_done_r   <= 1'b0;
            illegal_r    <= 1'b0;
            host_ready_r <= 1'b1;
        end else begin
            cmd_r        <= cmd_s;
            cmd_valid_r  <= cmd_valid_s;
            seq_done_r   <= seq_done_s;
            illegal_r    <= drop_s;
            host_ready_r <= host_ready_s;
        end
    end

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_r;
    logic          timeout_err_r;
    logic          in_wait_s;

    assign in_wait_s     = (state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO);
    assign tmo_expired_s = in_wait_s && (tmo_cnt_r == CW'(TIMEOUT - 1));

    // Wait-state cycle counter; cleared whenever the FSM is outside WAIT_*.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (in_wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= {CW{1'b0}};
        end
    end

    // Sticky timeout flag; set when the watchdog (not done) ends the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_r <= 1'b0;
        end else if (tmo_expired_s && !done) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign tmo_expired_s = 1'b0;
`endif

    assign host_ready  = host_ready_r;
    assign cmd         = cmd_r;
    assign cmd_valid   = cmd_valid_r;
    assign fifo_level  = level_r;
    assign illegal_cmd = illegal_r;
    assign seq_done    = seq_done_r;

endmodule
